fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-domain controller for the asynchronous FIFO: the parametrised successor to the basic read-pointer block. Generates the binary memory read address and the registered Gray read pointer for the write-domain synchroniser. Derives registered empty/almost-empty flags, a read-side fill level and an underflow pulse from the synchronised Gray write pointer. Optionally adds a first-word-fall-through (FWFT) output stage. Sits between the 2-flop write-pointer synchroniser and the dual-port FIFO memory, which reads combinationally from `rd_addr`.

## Interface
- `ADDR_W`, 3: memory address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- `DATA_W`, 8: data width.
- `AEMPTY_TH`, 2: almost-empty threshold in entries, 0..2**ADDR_W.
- `r_clk` in 1: read-domain clock.
- `r_rstn` in 1: reset, asynchronous, active-low.
- `r_inc` in 1: read request / pop.
- `sync_wr_ptr` in ADDR_W+1: synchronised Gray write pointer.
- `mem_rd_data` in DATA_W: memory read data at `rd_addr`.
- `rd_addr` out ADDR_W: binary read address = rd_ptr[ADDR_W-1:0].
- `gray_rd_ptr` out ADDR_W+1: registered Gray read pointer.
- `rd_data` out DATA_W: read data to the consumer.
- `empty` out 1: no data available to the consumer.
- `almost_empty` out 1: level <= AEMPTY_TH.
- `rd_level` out ADDR_W+1: entries visible to the read side, 0..2**ADDR_W.
- `underflow` out 1: one-cycle pulse, pop was rejected.

## Operation
- Internal binary pointer `rd_ptr` (ADDR_W+1 bits) wraps modulo 2**(ADDR_W+1).
- `pop` is the internal memory pop; `rd_ptr_nxt = rd_ptr + pop`.
- `empty_int` (registered) <= (bin2gray(rd_ptr_nxt) == sync_wr_ptr).
- `gray_rd_ptr` <= bin2gray(rd_ptr_nxt). It changes by at most one bit per cycle and equals bin2gray(rd_ptr) at all times.
- `wr_bin = gray2bin(sync_wr_ptr)`. `mem_level = (wr_bin - rd_ptr_nxt)` mod 2**(ADDR_W+1), registered.
- **Standard mode** (macro undefined):
  - pop = r_inc & ~empty_int.
  - empty = empty_int.
  - rd_data = mem_rd_data (combinational).
  - rd_level = mem_level.
  - underflow <= r_inc & empty_int.
- **FWFT mode**: two-state output stage, S_EMPTY / S_VALID, with output register `rd_data_q`.
  - pop = ~empty_int & (S_EMPTY | r_inc). A pop loads `rd_data_q` <= mem_rd_data.
  - S_EMPTY -> S_VALID on pop.
  - S_VALID & r_inc & ~pop -> S_EMPTY.
  - S_VALID & r_inc & pop stays in S_VALID; the new word replaces the old one in the same cycle.
  - empty = (state == S_EMPTY).
  - rd_data = rd_data_q.
  - rd_level = mem_level + (state == S_VALID).
  - underflow <= r_inc & (state == S_EMPTY).
- almost_empty <= (next rd_level <= AEMPTY_TH). This is registered and coherent with rd_level.
- A rejected pop (while empty) changes nothing except `underflow`.
- Wrap: rd_ptr 2**(ADDR_W+1)-1 -> 0 is a normal increment. Level arithmetic is modulo, so it stays correct across the wrap.
- Reset values, forced asynchronously at any time including mid-transfer:
  - rd_ptr = 0, gray_rd_ptr = 0.
  - empty = 1, empty_int = 1, almost_empty = 1.
  - rd_level = 0, underflow = 0.
  - state = S_EMPTY, rd_data_q = 0.
  - Data held in the output stage is discarded.

## Timing
- sync_wr_ptr change at edge N: empty_int and mem_level update at edge N+1.
- Standard mode: `empty` falls at N+1. The first read data is valid combinationally once it falls.
- FWFT mode: pop occurs in cycle N+1; rd_data and S_VALID are valid after edge N+2.
- Pop at edge N: gray_rd_ptr updates at edge N, so the write side sees it after its 2-flop synchroniser.
- Flags are pessimistic only:
  - empty can stay asserted late, never deassert early.
  - Level can under-report, never over-report.
- Sustained throughput: one word per cycle in both modes, while data is available.

## Configuration
- `FIFO_RD_FWFT_EN`:
  - Defined: FWFT output stage, state machine and rd_data_q are built.
  - Undefined: standard mode as above; no output register, rd_data passes through from memory.
- Port list is identical in both builds.

## Structure
- Shared package `fifo_pkg`:
  - functions bin2gray / gray2bin, parametrised by width;
  - FWFT state enum (S_EMPTY, S_VALID).
- The write-side successor uses the same package.
- One sub-module: `fifo_gray2bin` (combinational, WIDTH parameter), instantiated for `sync_wr_ptr`.

## Test plan
- Reset release with sync_wr_ptr=0 -> empty=1, almost_empty=1, rd_level=0, gray_rd_ptr=0; r_inc=1 -> underflow pulses one cycle, rd_addr stays 0.
- ADDR_W=3: step sync_wr_ptr through the Gray codes of 1..8 -> rd_level follows 1..8 one cycle late; almost_empty deasserts at level 3 (AEMPTY_TH=2).
- Fill 8, then pop 20 words with continuous refill -> rd_ptr wraps 15->0, gray_rd_ptr changes one bit per step, data order is preserved, empty never asserts early.
- FWFT: write pointer 0->1 at edge N -> rd_valid (~empty) after N+2 with word 0 on rd_data; then pop and refill in the same cycle -> rd_data advances with no bubble.
- FWFT: with one word held, r_inc plus simultaneous arrival of a second word -> state stays S_VALID; rd_level goes 2->1.
- Assert r_rstn low mid-burst with 5 words held -> all outputs return to reset values asynchronously; after release, empty=1 until sync_wr_ptr changes.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the FWFT output-stage state type.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_VALID = 1'b1
   } fwft_state_t;

   // Callers zero-extend narrower pointers to GRAY_MAX_W and truncate the result.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module fifo_gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);
   import fifo_pkg::*;

   always_comb begin
      bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO: read pointers, empty/almost-empty, level, underflow.
// Define FIFO_RD_FWFT_EN to build the first-word-fall-through output stage.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W    = 3,
   parameter int DATA_W    = 8,
   parameter int AEMPTY_TH = 2
) (
   input  logic              r_clk,
   input  logic              r_rstn,
   input  logic              r_inc,
   input  logic [ADDR_W:0]   sync_wr_ptr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   gray_rd_ptr,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   rd_level,
   output logic              underflow
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W:0] AE_TH = (PTR_W + 1)'(AEMPTY_TH);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [PTR_W-1:0] rd_gray_nxt;
   logic [PTR_W-1:0] wr_bin;
   logic [PTR_W-1:0] mem_level;
   logic [PTR_W-1:0] mem_level_nxt;
   logic [PTR_W:0]   level_nxt;
   logic             empty_int;
   logic             pop;

   fifo_gray2bin #(
      .WIDTH(PTR_W)
   ) u_wr_gray2bin (
      .gray(sync_wr_ptr),
      .bin (wr_bin)
   );

   assign rd_ptr_nxt    = rd_ptr + PTR_W'(pop);
   assign rd_gray_nxt   = PTR_W'(bin2gray(GRAY_MAX_W'(rd_ptr_nxt)));
   assign mem_level_nxt = wr_bin - rd_ptr_nxt;
   assign rd_addr       = rd_ptr[ADDR_W-1:0];

   // Flags look at the post-pop pointer so they are never optimistic.
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         rd_ptr       <= '0;
         gray_rd_ptr  <= '0;
         empty_int    <= 1'b1;
         mem_level    <= '0;
         almost_empty <= 1'b1;
      end else begin
         rd_ptr       <= rd_ptr_nxt;
         gray_rd_ptr  <= rd_gray_nxt;
         empty_int    <= (rd_gray_nxt == sync_wr_ptr);
         mem_level    <= mem_level_nxt;
         almost_empty <= (level_nxt <= AE_TH);
      end
   end

`ifdef FIFO_RD_FWFT_EN

   fwft_state_t       state;
   fwft_state_t       state_nxt;
   logic [DATA_W-1:0] rd_data_q;

   // Prefetch into the output register whenever it is empty or being consumed.
   assign pop = ~empty_int & ((state == S_EMPTY) | r_inc);

   always_comb begin
      state_nxt = state;
      if (pop) begin
         state_nxt = S_VALID;
      end else if (r_inc) begin
         state_nxt = S_EMPTY;
      end
   end

   assign level_nxt = {1'b0, mem_level_nxt} + (PTR_W + 1)'(state_nxt == S_VALID);

   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         state     <= S_EMPTY;
         rd_data_q <= '0;
         underflow <= 1'b0;
      end else begin
         state     <= state_nxt;
         underflow <= r_inc & (state == S_EMPTY);
         if (pop) begin
            rd_data_q <= mem_rd_data;
         end
      end
   end

   assign empty    = (state == S_EMPTY);
   assign rd_data  = rd_data_q;
   assign rd_level = mem_level + PTR_W'(state == S_VALID);

`else

   assign pop       = r_inc & ~empty_int;
   assign level_nxt = {1'b0, mem_level_nxt};

   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         underflow <= 1'b0;
      end else begin
         underflow <= r_inc & empty_int;
      end
   end

   assign empty    = empty_int;
   assign rd_data  = mem_rd_data;
   assign rd_level = mem_level;

`endif

endmodule
